ssd_driver: RTL

Drives the board's 4-digit seven-segment display from the CPU's 13-bit `ssd` output. It sits directly downstream of the RISCV core in the FPGA top level. It converts the binary value to four BCD digits with a sequential double-dabble converter, then time-multiplexes the digits onto shared active-low cathodes with one-hot active-low anodes.

---
 rtl/ssd_pkg.sv | 48 ++++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/ssd_driver.sv | 71 +++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types, segment codes and BCD-to-segment decode for the seven-segment driver.
package ssd_pkg;

    localparam int BIN_W  = 13;
    localparam int BCD_W  = 16;
    localparam int WORK_W = BIN_W + BCD_W;

    localparam logic [3:0] SHIFT_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_e;

    // Active-low segments, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble: IDLE -> LOAD -> 13x SHIFT -> COMMIT, 16 cycles per result.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    conv_state_e       state, state_n;
    logic [WORK_W-1:0] work, work_n, adj;
    logic [3:0]        cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        done    = 1'b0;
        adj     = work;
        for (int i = 0; i < 4; i++) begin
            if (work[BIN_W+4*i +: 4] >= 4'd5)
                adj[BIN_W+4*i +: 4] = work[BIN_W+4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE: state_n = LOAD;
            LOAD: begin
                work_n  = {{BCD_W{1'b0}}, bin};
                cnt_n   = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                // correct nibbles first, then shift: one dabble step per cycle
                work_n = {adj[WORK_W-2:0], 1'b0};
                cnt_n  = cnt + 4'd1;
                if (cnt == SHIFT_LAST)
                    state_n = COMMIT;
            end
            COMMIT: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bcd = work[WORK_W-1 -: BCD_W];

endmodule

// File: rtl/ssd_driver.sv
// 4-digit multiplexed seven-segment driver: BCD conversion, leading-zero blanking, scan.
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] ssd,
    output logic [3:0]       anode,
    output logic [6:0]       cathode,
    output logic             dp,
    output logic             conv_done
);

    localparam int              CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx, idx_n;
    logic [BCD_W-1:0] digits, digits_n, bcd;
    logic             done, wrap, lz;
    logic [3:0]       nib, anode_n;
    logic [6:0]       cathode_n;

    bin2bcd_seq u_conv (
        .clk  (clk),
        .rst  (rst),
        .bin  (ssd),
        .bcd  (bcd),
        .done (done)
    );

    assign conv_done = done;
    assign dp        = 1'b1;

    // Outputs are built from next-state index and digits so a commit and a
    // digit switch landing on the same edge show up together, never ghosted.
    always_comb begin
        wrap     = (refresh_cnt == CNT_MAX);
        idx_n    = wrap ? digit_idx + 2'd1 : digit_idx;
        digits_n = done ? bcd : digits;
        nib      = digits_n[{idx_n, 2'b00} +: 4];
        case (idx_n)
            2'd3:    lz = (digits_n[15:12] == 4'd0);
            2'd2:    lz = (digits_n[15:8] == 8'd0);
            2'd1:    lz = (digits_n[15:4] == 12'd0);
            default: lz = 1'b0;
        endcase
        anode_n   = ~(4'b0001 << idx_n);
        cathode_n = ((BLANK_LZ != 0) && lz) ? SEG_BLANK : seg_decode(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            digits      <= '0;
            anode       <= 4'b1111;
            cathode     <= SEG_BLANK;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CNT_W'(1);
            digit_idx   <= idx_n;
            digits      <= digits_n;
            anode       <= anode_n;
            cathode     <= cathode_n;
        end
    end

endmodule
